wbicape6: RTL and testbench

- Wishbone slave that converts single register accesses into the Spartan-6 ICAP packet sequences: sync, type-1 header, data, desync.
- Sits directly upstream of the ICAP_SPARTAN6 primitive. It drives that primitive's CE, WRITE and I pins and consumes its O and BUSY pins.
- Lets the CPU read and write configuration registers such as IDCODE, STAT, GENERAL1-5 and CMD, for example to trigger a warm-boot IPROG.

---
 rtl/wbicape6.sv | 197 +++++++++++++++++++
 tb/tb_wbicape6.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbicape6.sv
// wbicape6: Wishbone slave bridging single register accesses onto ICAP_SPARTAN6.
// Every access emits a full sync / type-1 header / data / desync packet sequence.

module wbicape6_brev8 #(
   parameter bit EN = 1'b1
) (
   input  logic [7:0] d,
   output logic [7:0] q
);
   always_comb begin
      q = d;
      if (EN)
         for (int i = 0; i < 8; i++) q[i] = d[7-i];
   end
endmodule

module wbicape6 #(
   parameter bit BIT_SWAP   = 1'b1,
   parameter int RD_TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [5:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic        o_icap_ce_n,
   output logic        o_icap_we_n,
   output logic [15:0] o_icap_data,
   input  logic [15:0] i_icap_data,
   input  logic        i_icap_busy,
   output logic        o_err
);
   localparam int NB = 2;
   localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE_SEQ, S_READ_SEQ, S_TURN_R, S_READ, S_TURN_W, S_DESYNC, S_ACK
   } state_t;

   state_t          state, state_d;
   logic [2:0]      cnt, cnt_d;
   logic [TW-1:0]   tmo, tmo_d;
   logic            we_q, we_d;
   logic [5:0]      addr_q, addr_d;
   logic [15:0]     data_q, data_d;
   logic            live, live_d;
   logic [15:0]     rd_q, rd_d;
   logic            err_d, ack_d, stall_d, ce_d, wen_d;
   logic [15:0]     word_d, hdr;
   logic            accept;
   logic [NB-1:0][7:0] word_sw, din_sw;
   logic            unused_hi;

   assign unused_hi = &{1'b0, i_wb_data[31:16]};
   assign accept    = i_wb_cyc & i_wb_stb & ~o_wb_stall;
   assign o_wb_data = {16'h0000, rd_q};

   // Byte-lane bit reversal, applied identically to the I and O buses.
   generate
      for (genvar b = 0; b < NB; b++) begin : g_lane
         wbicape6_brev8 #(.EN(BIT_SWAP)) u_tx (.d(word_d[8*b +: 8]),      .q(word_sw[b]));
         wbicape6_brev8 #(.EN(BIT_SWAP)) u_rx (.d(i_icap_data[8*b +: 8]), .q(din_sw[b]));
      end
   endgenerate

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      tmo_d   = tmo;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      live_d  = live & i_wb_cyc;
      rd_d    = rd_q;
      err_d   = 1'b0;
      unique case (state)
         S_IDLE: if (accept) begin
            state_d = i_wb_we ? S_WRITE_SEQ : S_READ_SEQ;
            cnt_d   = 3'd0;
            we_d    = i_wb_we;
            addr_d  = i_wb_addr;
            data_d  = i_wb_data[15:0];
            live_d  = 1'b1;
         end
         S_WRITE_SEQ: if (cnt == 3'd7) begin
            state_d = S_DESYNC;
            cnt_d   = 3'd0;
         end else cnt_d = cnt + 3'd1;
         S_READ_SEQ: if (cnt == 3'd6) begin
            state_d = S_TURN_R;
            cnt_d   = 3'd0;
         end else cnt_d = cnt + 3'd1;
         S_TURN_R: if (cnt == 3'd1) begin
            state_d = S_READ;
            cnt_d   = 3'd0;
            tmo_d   = '0;
         end else cnt_d = cnt + 3'd1;
         S_READ: if (!i_icap_busy) begin
            rd_d    = din_sw;
            state_d = S_TURN_W;
            cnt_d   = 3'd0;
         end else if (tmo == TW'(RD_TIMEOUT - 1)) begin
            rd_d    = 16'h0000;
            err_d   = 1'b1;
            state_d = S_TURN_W;
            cnt_d   = 3'd0;
         end else tmo_d = tmo + TW'(1);
         S_TURN_W: if (cnt == 3'd1) begin
            state_d = S_DESYNC;
            cnt_d   = 3'd0;
         end else cnt_d = cnt + 3'd1;
         S_DESYNC: if (cnt == 3'd3) begin
            state_d = S_ACK;
            cnt_d   = 3'd0;
         end else cnt_d = cnt + 3'd1;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pin values are decoded from the next state so the ICAP sees registered outputs.
   always_comb begin
      ce_d    = 1'b1;
      wen_d   = 1'b0;
      word_d  = 16'hFFFF;
      hdr     = (we_d ? 16'h3001 : 16'h2801) | {5'd0, addr_d, 5'd0};
      ack_d   = (state_d == S_ACK) & live_d;
      stall_d = (state_d != S_IDLE);
      case (state_d)
         S_WRITE_SEQ, S_READ_SEQ: begin
            ce_d = 1'b0;
            case (cnt_d)
               3'd0:    word_d = 16'hFFFF;
               3'd1:    word_d = 16'hAA99;
               3'd2:    word_d = 16'h5566;
               3'd4:    word_d = hdr;
               3'd5:    word_d = we_d ? data_d : 16'h2000;
               default: word_d = 16'h2000;
            endcase
         end
         S_TURN_R: wen_d = (cnt_d == 3'd1);
         S_READ: begin
            ce_d  = 1'b0;
            wen_d = 1'b1;
         end
         S_TURN_W: wen_d = (cnt_d == 3'd0);
         S_DESYNC: begin
            ce_d = 1'b0;
            case (cnt_d)
               3'd0:    word_d = 16'h30A1;
               3'd1:    word_d = 16'h000D;
               default: word_d = 16'h2000;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         cnt         <= 3'd0;
         tmo         <= '0;
         we_q        <= 1'b0;
         addr_q      <= 6'd0;
         data_q      <= 16'h0000;
         live        <= 1'b0;
         rd_q        <= 16'h0000;
         o_wb_ack    <= 1'b0;
         o_wb_stall  <= 1'b0;
         o_icap_ce_n <= 1'b1;
         o_icap_we_n <= 1'b0;
         o_icap_data <= 16'hFFFF;
         o_err       <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         tmo         <= tmo_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         live        <= live_d;
         rd_q        <= rd_d;
         o_wb_ack    <= ack_d;
         o_wb_stall  <= stall_d;
         o_icap_ce_n <= ce_d;
         o_icap_we_n <= wen_d;
         o_icap_data <= word_sw;
         o_err       <= err_d;
      end
   end
endmodule

// File: tb/tb_wbicape6.sv
// Self-checking bench for wbicape6: pin traces compared against a per-access
// packet model built from the ICAP sequencing rules.

module tb_wbicape6;
   localparam int MAXC  = 400;
   localparam int NEVER = 100000;

   logic        clk = 1'b0;
   logic        rst, cyc, stb, we, busy;
   logic [5:0]  addr;
   logic [31:0] wdat;
   logic [15:0] icap_in;
   logic        ack0, stall0, ce0, wen0, err0, ack1, stall1, ce1, wen1, err1;
   logic [31:0] wbd0, wbd1;
   logic [15:0] id0, id1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wbicape6 #(.BIT_SWAP(1'b0), .RD_TIMEOUT(255)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(ack0), .o_wb_stall(stall0),
      .o_wb_data(wbd0), .o_icap_ce_n(ce0), .o_icap_we_n(wen0), .o_icap_data(id0),
      .i_icap_data(icap_in), .i_icap_busy(busy), .o_err(err0));

   wbicape6 #(.BIT_SWAP(1'b1), .RD_TIMEOUT(255)) u_dut_sw (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(ack1), .o_wb_stall(stall1),
      .o_wb_data(wbd1), .o_icap_ce_n(ce1), .o_icap_we_n(wen1), .o_icap_data(id1),
      .i_icap_data(icap_in), .i_icap_busy(busy), .o_err(err1));

   // captured trace; index 0 is the cycle after acceptance
   logic        c_ce[MAXC], c_we[MAXC], c_ack[MAXC], c_stall[MAXC], c_err[MAXC], c_ack1[MAXC];
   logic [15:0] c_d0[MAXC], c_d1[MAXC];
   logic [31:0] c_wbd0[MAXC], c_wbd1[MAXC];
   int          n_obs;

   // model trace
   bit          m_ce[$], m_we[$], m_dv[$];
   logic [15:0] m_d[$];

   function automatic logic [15:0] bswap(input logic [15:0] w);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i]     = w[7-i];
         r[8+i]   = w[15-i];
      end
      return r;
   endfunction

   function automatic void push_w(input logic [15:0] w);
      m_ce.push_back(1'b0); m_we.push_back(1'b0); m_dv.push_back(1'b1); m_d.push_back(w);
   endfunction

   function automatic void push_n(input bit ce, input bit wn);
      m_ce.push_back(ce); m_we.push_back(wn); m_dv.push_back(1'b0); m_d.push_back(16'hFFFF);
   endfunction

   function automatic void build_model(input bit w, input bit [5:0] a, input bit [15:0] d, input int nread);
      logic [15:0] hdr;
      m_ce.delete(); m_we.delete(); m_dv.delete(); m_d.delete();
      hdr = (w ? 16'h3001 : 16'h2801) | (16'(a) << 5);
      push_w(16'hFFFF); push_w(16'hAA99); push_w(16'h5566); push_w(16'h2000);
      push_w(hdr); push_w(w ? d : 16'h2000); push_w(16'h2000);
      if (w) push_w(16'h2000);
      else begin
         push_n(1, 0); push_n(1, 1);
         repeat (nread) push_n(0, 1);
         push_n(1, 1); push_n(1, 0);
      end
      push_w(16'h30A1); push_w(16'h000D); push_w(16'h2000); push_w(16'h2000);
   endfunction

   // Issue one access and record pins each cycle until stall falls again.
   task automatic capture(input bit w, input bit [5:0] a, input bit [15:0] d, input int busy_k,
                          input bit [15:0] rdval, input int drop_at, input int rst_at, input bit hold_stb);
      int rdcnt = 0;
      bit rd_now;
      for (int i = 0; i < MAXC; i++) begin
         c_ce[i] = 'x; c_we[i] = 'x; c_ack[i] = 'x; c_stall[i] = 'x; c_err[i] = 'x;
         c_ack1[i] = 'x; c_d0[i] = 'x; c_d1[i] = 'x; c_wbd0[i] = 'x; c_wbd1[i] = 'x;
      end
      n_obs = 0;
      @(negedge clk);
      cyc = 1; stb = 1; we = w; addr = a; wdat = {16'($urandom), d};
      busy = 1'($urandom); icap_in = 16'($urandom);
      @(posedge clk); #1;
      if (!hold_stb) stb = 0;
      for (int i = 0; i < MAXC; i++) begin
         @(negedge clk);
         c_ce[i] = ce0; c_we[i] = wen0; c_ack[i] = ack0; c_stall[i] = stall0; c_err[i] = err0;
         c_ack1[i] = ack1; c_d0[i] = id0; c_d1[i] = id1; c_wbd0[i] = wbd0; c_wbd1[i] = wbd1;
         n_obs = i + 1;
         if (ack0) stb = 0;
         if (!stall0) begin
            rst = 0; cyc = 0; stb = 0;
            break;
         end
         if (i + 1 == drop_at) cyc = 0;
         if (i + 1 == rst_at) rst = 1;
         rd_now = (ce0 == 1'b0 && wen0 == 1'b1);
         if (rd_now) rdcnt++;
         if (rd_now && rdcnt == busy_k) begin
            busy = 0; icap_in = rdval;
         end else begin
            busy = rd_now ? 1'b1 : 1'($urandom);
            icap_in = 16'($urandom);
         end
      end
      cyc = 0; stb = 0; rst = 0;
   endtask

   task automatic test_reset;
      rst = 1; cyc = 0; stb = 0; we = 0; addr = 0; wdat = 0; busy = 1; icap_in = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ack0, stall0, wbd0, ce0, wen0, id0, err0} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'hFFFF, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_dut0: ack=%b stall=%b wbd=%h ce=%b we=%b d=%h err=%b, want 0 0 0 1 0 ffff 0",
                  ack0, stall0, wbd0, ce0, wen0, id0, err0);
      end
      n_checks++;
      if ({ack1, stall1, wbd1, ce1, wen1, id1, err1} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'hFFFF, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_dut1: ack=%b stall=%b wbd=%h ce=%b we=%b d=%h err=%b, want 0 0 0 1 0 ffff 0",
                  ack1, stall1, wbd1, ce1, wen1, id1, err1);
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_write;
      bit [5:0] a; bit [15:0] d; int L;
      for (int t = 0; t < 4; t++) begin
         a = (t == 0) ? 6'h08 : 6'($urandom);
         d = (t == 0) ? 16'h1234 : 16'($urandom);
         capture(1, a, d, NEVER, 16'h0, 0, 0, 0);
         build_model(1, a, d, 0);
         L = m_ce.size();
         for (int j = 0; j < L; j++) begin
            n_checks++;
            if (c_ce[j] !== m_ce[j] || c_we[j] !== m_we[j] || c_d0[j] !== m_d[j] ||
                c_stall[j] !== 1'b1 || c_ack[j] !== 1'b0) begin
               n_errors++;
               $display("FAIL write_trace a=%h cyc%0d: ce=%b we=%b d=%h stall=%b ack=%b, want ce=%b we=%b d=%h stall=1 ack=0",
                        a, j + 1, c_ce[j], c_we[j], c_d0[j], c_stall[j], c_ack[j], m_ce[j], m_we[j], m_d[j]);
            end
         end
         n_checks++;
         if (c_ack[L] !== 1'b1 || c_stall[L] !== 1'b1 || c_stall[L+1] !== 1'b0 || c_ack[L+1] !== 1'b0 || L != 12) begin
            n_errors++;
            $display("FAIL write_ack cyc13: ack=%b stall=%b then stall=%b ack=%b, want 1 1 then 0 0",
                     c_ack[L], c_stall[L], c_stall[L+1], c_ack[L+1]);
         end
      end
   endtask

   task automatic test_read;
      bit [5:0] a; bit [15:0] rv; int k, L, errs;
      for (int t = 0; t < 4; t++) begin
         a  = (t == 0) ? 6'h0A : 6'($urandom);
         rv = (t == 0) ? 16'h4000 : 16'($urandom);
         k  = (t == 0) ? 3 : int'($urandom_range(1, 20));
         capture(0, a, 16'($urandom), k, rv, 0, 0, 0);
         build_model(0, a, 16'h0, k);
         L = m_ce.size();
         errs = 0;
         for (int j = 0; j < L; j++) begin
            if (c_err[j] === 1'b1) errs++;
            n_checks++;
            if (c_ce[j] !== m_ce[j] || c_we[j] !== m_we[j] || (m_dv[j] && c_d0[j] !== m_d[j]) ||
                c_stall[j] !== 1'b1 || c_ack[j] !== 1'b0) begin
               n_errors++;
               $display("FAIL read_trace a=%h cyc%0d: ce=%b we=%b d=%h stall=%b ack=%b, want ce=%b we=%b d=%h stall=1 ack=0",
                        a, j + 1, c_ce[j], c_we[j], c_d0[j], c_stall[j], c_ack[j], m_ce[j], m_we[j], m_d[j]);
            end
         end
         n_checks++;
         if (c_ack[L] !== 1'b1 || c_wbd0[L] !== {16'h0, rv} || c_stall[L+1] !== 1'b0 || errs != 0) begin
            n_errors++;
            $display("FAIL read_ack: ack=%b wbd=%h stall_after=%b errs=%0d, want ack=1 wbd=%h stall_after=0 errs=0",
                     c_ack[L], c_wbd0[L], c_stall[L+1], errs, {16'h0, rv});
         end
         n_checks++;
         if (c_ack1[L] !== 1'b1 || c_wbd1[L] !== {16'h0, bswap(rv)}) begin
            n_errors++;
            $display("FAIL read_swap: ack=%b wbd=%h, want ack=1 wbd=%h", c_ack1[L], c_wbd1[L], {16'h0, bswap(rv)});
         end
      end
   endtask

   task automatic test_read_timeout;
      bit [5:0] a; int L, errs;
      a = 6'($urandom);
      capture(0, a, 16'h0, NEVER, 16'h0, 0, 0, 0);
      build_model(0, a, 16'h0, 255);
      L = m_ce.size();
      errs = 0;
      for (int j = 0; j < n_obs; j++) if (c_err[j] === 1'b1) errs++;
      for (int j = 0; j < L; j++) begin
         n_checks++;
         if (c_ce[j] !== m_ce[j] || c_we[j] !== m_we[j] || (m_dv[j] && c_d0[j] !== m_d[j])) begin
            n_errors++;
            $display("FAIL timeout_trace cyc%0d: ce=%b we=%b d=%h, want ce=%b we=%b d=%h",
                     j + 1, c_ce[j], c_we[j], c_d0[j], m_ce[j], m_we[j], m_d[j]);
         end
      end
      n_checks++;
      if (errs != 1 || c_err[7+2+255] !== 1'b1) begin
         n_errors++;
         $display("FAIL timeout_err: pulses=%0d at_expected=%b, want pulses=1 at_expected=1", errs, c_err[7+2+255]);
      end
      n_checks++;
      if (c_ack[L] !== 1'b1 || c_wbd0[L] !== 32'h0) begin
         n_errors++;
         $display("FAIL timeout_ack: ack=%b wbd=%h, want ack=1 wbd=00000000", c_ack[L], c_wbd0[L]);
      end
   endtask

   task automatic test_bit_swap;
      bit [5:0] a; bit [15:0] d; int L;
      a = 6'($urandom); d = 16'($urandom);
      capture(1, a, d, NEVER, 16'h0, 0, 0, 0);
      build_model(1, a, d, 0);
      L = m_ce.size();
      n_checks++;
      if (c_d1[1] !== 16'h5599 || c_d1[2] !== 16'hAA66) begin
         n_errors++;
         $display("FAIL swap_sync: w1=%h w2=%h, want 5599 aa66", c_d1[1], c_d1[2]);
      end
      for (int j = 0; j < L; j++) begin
         n_checks++;
         if (c_d1[j] !== bswap(m_d[j])) begin
            n_errors++;
            $display("FAIL swap_trace cyc%0d: d=%h, want %h", j + 1, c_d1[j], bswap(m_d[j]));
         end
      end
   endtask

   task automatic test_cyc_drop;
      bit [5:0] a; bit [15:0] d; int L, acks;
      a = 6'($urandom); d = 16'($urandom);
      capture(1, a, d, NEVER, 16'h0, 4, 0, 0);
      build_model(1, a, d, 0);
      L = m_ce.size();
      acks = 0;
      for (int j = 0; j < n_obs; j++) if (c_ack[j] !== 1'b0) acks++;
      for (int j = 0; j < L; j++) begin
         n_checks++;
         if (c_ce[j] !== m_ce[j] || c_we[j] !== m_we[j] || c_d0[j] !== m_d[j]) begin
            n_errors++;
            $display("FAIL drop_trace cyc%0d: ce=%b we=%b d=%h, want ce=%b we=%b d=%h",
                     j + 1, c_ce[j], c_we[j], c_d0[j], m_ce[j], m_we[j], m_d[j]);
         end
      end
      n_checks++;
      if (acks != 0 || n_obs != L + 2) begin
         n_errors++;
         $display("FAIL drop_noack: acks=%0d cycles=%0d, want acks=0 cycles=%0d", acks, n_obs, L + 2);
      end
   endtask

   task automatic test_stalled_strobe;
      int acks, ces;
      capture(1, 6'($urandom), 16'($urandom), NEVER, 16'h0, 0, 0, 1);
      acks = 0;
      for (int j = 0; j < n_obs; j++) if (c_ack[j] === 1'b1) acks++;
      n_checks++;
      if (acks != 1 || c_ack[12] !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_ack: acks=%0d ack13=%b, want acks=1 ack13=1", acks, c_ack[12]);
      end
      ces = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         if (ce0 !== 1'b1 || stall0 !== 1'b0) ces++;
      end
      n_checks++;
      if (ces != 0) begin
         n_errors++;
         $display("FAIL stall_noqueue: busy_cycles=%0d, want 0", ces);
      end
   endtask

   task automatic test_reset_mid;
      bit [5:0] a; bit [15:0] d; int L;
      capture(0, 6'($urandom), 16'h0, NEVER, 16'h0, 0, 6, 0);
      n_checks++;
      if (n_obs != 7 || c_ce[6] !== 1'b1 || c_we[6] !== 1'b0 || c_stall[6] !== 1'b0 ||
          c_d0[6] !== 16'hFFFF || c_ack[6] !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_mid: cycles=%0d ce=%b we=%b stall=%b d=%h ack=%b, want 7 1 0 0 ffff 0",
                  n_obs, c_ce[6], c_we[6], c_stall[6], c_d0[6], c_ack[6]);
      end
      a = 6'($urandom); d = 16'($urandom);
      capture(1, a, d, NEVER, 16'h0, 0, 0, 0);
      build_model(1, a, d, 0);
      L = m_ce.size();
      for (int j = 0; j < L; j++) begin
         n_checks++;
         if (c_ce[j] !== m_ce[j] || c_we[j] !== m_we[j] || c_d0[j] !== m_d[j]) begin
            n_errors++;
            $display("FAIL rst_rewrite cyc%0d: ce=%b we=%b d=%h, want ce=%b we=%b d=%h",
                     j + 1, c_ce[j], c_we[j], c_d0[j], m_ce[j], m_we[j], m_d[j]);
         end
      end
      n_checks++;
      if (c_ack[12] !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_rewrite_ack: ack13=%b, want 1", c_ack[12]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_read_timeout();
      test_bit_swap();
      test_cyc_drop();
      test_stalled_strobe();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
